mac_dot_sequencer: RTL
======================

Name: mac_dot_sequencer

Overview:
- Upstream feeder and result collector for the 8x8 multiply-accumulate unit (17-bit registered accumulator with clear).
- Accepts operand pairs over a valid/ready stream and presents them to the MAC one per cycle.
- After LEN pairs it waits out the MAC pipeline and captures the 17-bit dot product into an output holding register with valid/ready.
- It then clears the accumulator for the next vector.

Parameters:
- LEN, 8, operand pairs per dot product (2..255).
- OP_W, 8, operand width; fixed to the MAC's a/b width.
- ACC_W, 17, accumulator/result width (2*OP_W+1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts a pair.
- in_a  in  OP_W  operand A.
- in_b  in  OP_W  operand B.
- mac_a  out  OP_W  registered operand to MAC a.
- mac_b  out  OP_W  registered operand to MAC b.
- acc_clr  out  1  synchronous accumulator clear to MAC, active-high.
- mac_acc  in  ACC_W  MAC accumulator output (registered in MAC).
- out_valid  out  1  dot product available.
- out_ready  in  1  consumer takes result.
- out_data  out  ACC_W  captured dot product.

Behaviour:
- Transfer = in_valid & in_ready at a rising edge. Output handshake = out_valid & out_ready.
- States: CLEAR, RUN, DRAIN, HOLD.
- Reset (reset=0, asynchronous): state=CLEAR, cnt=0, mac_a=mac_b=0, out_data=0, out_valid=0, in_ready=0, acc_clr=1.
- acc_clr = (state==CLEAR).
- CLEAR: lasts exactly one cycle, then RUN with cnt=0.
- RUN: in_ready=1. On each transfer, mac_a/mac_b <= in_a/in_b and cnt++. With no transfer, mac_a/mac_b <= 0, so the accumulator adds 0 and holds. The transfer that makes cnt==LEN moves to DRAIN with drain counter=2.
- DRAIN: in_ready=0, mac_a/mac_b <= 0. Decrement drain counter each cycle. On the cycle it reads 1, out_data <= mac_acc and go to HOLD.
- Timing: last pair accepted at edge ending cycle t. MAC sees it in t+1, mac_acc includes it in t+2 (captured at end of t+2), out_valid=1 in t+3.
- HOLD: out_valid=1, out_data stable, in_ready=0. On output handshake: out_valid <= 0, go to CLEAR.
- Throughput: one vector per LEN+4 cycles with in_valid and out_ready held high.
- Arithmetic: products ≤ 65025. out_data is mac_acc verbatim, modulo 2^17 wrap with no saturation.
- in_valid while not in RUN is ignored. in_a/in_b need not be stable when in_ready=0.
- out_ready without out_valid has no effect.
- Reset mid-operation (any state) aborts the vector, discards partial sums, and restarts in CLEAR.
- LEN counter width = clog2(LEN+1).

Optional Feature:
- Macro: MAC_OVF_DETECT_EN.
- With the macro defined:
  - Adds output port out_ovf (1 bit) and a register prev_acc (ACC_W).
  - prev_acc <= mac_acc every cycle in RUN/DRAIN and is cleared in CLEAR.
  - Sticky flag set if mac_acc < prev_acc (accumulation is monotonic, so a decrease means 17-bit wrap).
  - out_ovf is captured alongside out_data, valid with out_valid, and reset to 0.
- Without the macro: no port and no logic; behaviour otherwise identical.

Decomposition:
- Package mac_seq_pkg holds:
  - state enum (CLEAR, RUN, DRAIN, HOLD);
  - OP_W/ACC_W constants;
  - DRAIN_CYCLES=2 constant, matching the MAC register latency.
- Single module; no sub-module needed. The overflow monitor stays inline under the macro.

Test Plan:
- LEN=4, pairs (1,1),(2,3),(4,5),(255,255) back-to-back, out_ready=1 -> out_data=65052, out_valid exactly 3 cycles after last transfer, acc_clr pulse next cycle.
- Two consecutive vectors LEN=4 of all (2,2) then all (3,3) -> out_data=16 then 36; second result unaffected by first (clear verified).
- in_valid gaps (valid every 3rd cycle) with pairs (10,10)x4 -> out_data=400; mac_a/mac_b=0 on idle cycles.
- out_ready low 5 cycles in HOLD -> out_valid stays 1, out_data stable, in_ready=0. Completes on first out_ready=1, then CLEAR.
- Assert reset=0 after 2 of 4 pairs, release, then send (1,1)x4 -> out_data=4, all outputs at reset values during reset.
- MAC_OVF_DETECT_EN, LEN=4, all (255,255) -> out_data=129028, out_ovf=1. Next vector (1,1)x4 -> out_data=4, out_ovf=0.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared types and constants for the MAC dot-product sequencer
// Purpose : state encoding, datapath widths and MAC pipeline depth.
// Ports   : none (package).
package mac_seq_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 2 * OP_W + 1;

  // Register stages between an accepted pair and its effect on mac_acc:
  // one operand register here plus the MAC accumulator register.
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// rtl/mac_dot_sequencer_if.sv - operand stream, MAC link and result stream bundle
// Purpose : groups every handshake/bus signal of the sequencer.
// Signals : in_valid/in_ready/in_a/in_b    operand pair stream
//           mac_a/mac_b/acc_clr/mac_acc     link to the 8x8 MAC
//           out_valid/out_ready/out_data    dot product result
//           out_ovf                         wrap flag (only with MAC_OVF_DETECT_EN)
// Modports: slave  - the sequencer
//           master - the environment driving it
interface mac_dot_sequencer_if;

  logic                             in_valid;
  logic                             in_ready;
  logic [mac_seq_pkg::OP_W-1:0]     in_a;
  logic [mac_seq_pkg::OP_W-1:0]     in_b;
  logic [mac_seq_pkg::OP_W-1:0]     mac_a;
  logic [mac_seq_pkg::OP_W-1:0]     mac_b;
  logic                             acc_clr;
  logic [mac_seq_pkg::ACC_W-1:0]    mac_acc;
  logic                             out_valid;
  logic                             out_ready;
  logic [mac_seq_pkg::ACC_W-1:0]    out_data;
`ifdef MAC_OVF_DETECT_EN
  logic                             out_ovf;
`endif

  modport slave (
    input  in_valid, in_a, in_b, mac_acc, out_ready,
`ifdef MAC_OVF_DETECT_EN
    output out_ovf,
`endif
    output in_ready, mac_a, mac_b, acc_clr, out_valid, out_data
  );

  modport master (
    output in_valid, in_a, in_b, mac_acc, out_ready,
`ifdef MAC_OVF_DETECT_EN
    input  out_ovf,
`endif
    input  in_ready, mac_a, mac_b, acc_clr, out_valid, out_data
  );

endinterface

// File: rtl/mac_dot_sequencer.sv
// rtl/mac_dot_sequencer.sv - feeds LEN operand pairs to the MAC and captures the dot product
// Purpose : CLEAR (1 cycle, acc_clr) -> RUN (accept LEN pairs) -> DRAIN (wait out
//           MAC latency, capture mac_acc) -> HOLD (present result until taken).
// Ports   : clk   - clock, rising edge
//           reset - asynchronous active-low reset
//           bus   - mac_dot_sequencer_if.slave (operand stream, MAC link, result)
// Macro   : MAC_OVF_DETECT_EN adds bus.out_ovf, a sticky 17-bit wrap flag captured
//           alongside out_data.
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mac_dot_sequencer_if.slave   bus
);

  localparam int CNT_W = $clog2(LEN + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          drain_q, drain_d;
  logic [OP_W-1:0]     mac_a_q, mac_a_d;
  logic [OP_W-1:0]     mac_b_q, mac_b_d;
  logic [ACC_W-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                acc_clr_q, acc_clr_d;

  logic xfer;
  logic out_hs;
  logic capture;

  assign xfer    = bus.in_valid & in_ready_q;
  assign out_hs  = out_valid_q & bus.out_ready;
  assign capture = (state_q == DRAIN) && (drain_q == 2'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    // Idle cycles feed zeros so the accumulator adds nothing and holds.
    mac_a_d     = '0;
    mac_b_d     = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      CLEAR: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        if (xfer) begin
          mac_a_d = bus.in_a;
          mac_b_d = bus.in_b;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LEN - 1)) begin
            state_d = DRAIN;
            drain_d = 2'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q - 2'd1;
        if (capture) begin
          out_data_d  = bus.mac_acc;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
    // Decoded from the next state so both strobes come straight from flops.
    in_ready_d = (state_d == RUN);
    acc_clr_d  = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      drain_q     <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      acc_clr_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      acc_clr_q   <= acc_clr_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

`ifdef MAC_OVF_DETECT_EN
  // The accumulator only ever grows within a vector, so any decrease of
  // mac_acc between consecutive cycles means it wrapped past 2^ACC_W.
  logic [ACC_W-1:0] prev_acc_q, prev_acc_d;
  logic             ovf_q, ovf_d;
  logic             out_ovf_q, out_ovf_d;
  logic             wrap;

  assign wrap = (bus.mac_acc < prev_acc_q);

  always_comb begin
    prev_acc_d = prev_acc_q;
    ovf_d      = ovf_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      CLEAR: begin
        prev_acc_d = '0;
        ovf_d      = 1'b0;
      end
      RUN, DRAIN: begin
        prev_acc_d = bus.mac_acc;
        ovf_d      = ovf_q | wrap;
      end
      default: ;
    endcase
    // Include this cycle's comparison: the capture cycle may be the wrap cycle.
    if (capture) out_ovf_d = ovf_q | wrap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_acc_q <= '0;
      ovf_q      <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      prev_acc_q <= prev_acc_d;
      ovf_q      <= ovf_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign bus.out_ovf = out_ovf_q;
`endif

endmodule
